// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises rx, frames start/data/stop bits on mid-bit ticks
// and hands completed bytes to a valid/ready consumer, flagging framing errors and overruns.
module uart_rx_frame #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 baud_ena,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_r;
  logic                 rx_meta_r;
  logic                 rx_sync_r;
  logic                 rx_s;
  logic                 deliver_ok_s;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic                 baud_ena_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Synchronised line value and whether a completed byte can be loaded this cycle.
  always_comb begin
    rx_s         = rx_sync_r;
    deliver_ok_s = !rx_valid_r || rx_ready;
  end

  // Frame state machine with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      bit_cnt_r   <= {CNT_W{1'b0}};
      shreg_r     <= {DATA_BITS{1'b0}};
      baud_ena_r  <= 1'b0;
      rx_data_r   <= {DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      // A later delivery in the same cycle overrides this clear.
      if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r    <= START;
            baud_ena_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            if (!rx_s) begin
              state_r   <= DATA;
              bit_cnt_r <= {CNT_W{1'b0}};
            end else begin
              state_r    <= IDLE;
              baud_ena_r <= 1'b0;
              busy_r     <= 1'b0;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            shreg_r   <= {rx_s, shreg_r[DATA_BITS-1:1]};
            bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= STOP;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            state_r    <= IDLE;
            baud_ena_r <= 1'b0;
            busy_r     <= 1'b0;
            if (!rx_s) begin
              frame_err_r <= 1'b1;
            end else if (deliver_ok_s) begin
              rx_data_r  <= shreg_r;
              rx_valid_r <= 1'b1;
            end else begin
              overrun_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_ena_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign baud_ena  = baud_ena_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame with a divide-by-16 mid-bit tick generator model.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       baud_tick;
  logic       baud_ena;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [3:0] div_cnt;

  int checks = 0;
  int failures = 0;

  typedef enum int {EV_DATA, EV_ERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  bit         pending = 1'b0;
  logic [7:0] exp_cur = 8'h00;
  bit         prev_valid = 1'b0;
  bit         prev_hs = 1'b0;

  always #5 clk = ~clk;

  uart_rx_frame #(.DATA_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .baud_tick(baud_tick), .baud_ena(baud_ena),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  // Tick generator: restarts at 0 whenever disabled, mid-bit tick at count 8.
  always_ff @(posedge clk) begin
    if (!rstn || !baud_ena) div_cnt <= 4'd0;
    else                    div_cnt <= div_cnt + 4'd1;
  end
  assign baud_tick = baud_ena && (div_cnt == 4'd8);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic drive_bit(logic v);
    rx = v;
    repeat (16) step();
  endtask

  task automatic push(ev_kind_t k, logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Consumer readiness only changes between frames; a ready consumer drains any pending byte.
  task automatic set_ready(bit r);
    rx_ready = r;
    if (r) pending = 1'b0;
  endtask

  // Outcome of one frame given the stop bit, consumer readiness and buffer occupancy.
  task automatic model_frame(logic [7:0] b, bit stop_ok);
    if (!stop_ok) push(EV_ERR, 8'h00);
    else if (rx_ready) push(EV_DATA, b);
    else if (pending) push(EV_OVR, 8'h00);
    else begin
      push(EV_DATA, b);
      pending = 1'b1;
    end
  endtask

  task automatic send_frame(logic [7:0] b, bit stop_ok);
    model_frame(b, stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    rx = 1'b1;
    if (stop_ok) check("baud_ena_after_frame", {31'd0, baud_ena}, 32'd0);
  endtask

  task automatic check_reset(string name);
    check(name, {19'd0, baud_ena, rx_valid, frame_err, overrun, busy, rx_data}, 32'd0);
  endtask

  task automatic pop_ev(ev_kind_t k, string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected event actual=%0d required=none", name, k);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        failures++;
        $display("FAIL %s event kind actual=%0d required=%0d", name, k, e.kind);
      end else if (k == EV_DATA) begin
        exp_cur = e.data;
      end
    end
  endtask

  // Monitor: every DUT-visible event must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_valid = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (frame_err) pop_ev(EV_ERR, "frame_err");
      if (overrun) pop_ev(EV_OVR, "overrun");
      if (rx_valid && (!prev_valid || prev_hs)) pop_ev(EV_DATA, "deliver");
      if (rx_valid) check("rx_data_held", {24'd0, rx_data}, {24'd0, exp_cur});
      prev_valid = rx_valid;
      prev_hs = rx_valid && rx_ready;
    end
  end

  initial begin
    bit         raised;
    bit         ok;
    logic [7:0] b;
    logic [7:0] b77;

    repeat (3) step();
    check_reset("reset_state");
    rstn = 1'b1;
    repeat (5) step();

    send_frame(8'hA5, 1'b1);
    idle(10);

    // Short low glitch: start bit rejected on the first tick.
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    repeat (3) step();
    check("glitch_baud_ena_high", {31'd0, baud_ena}, 32'd1);
    repeat (30) step();
    check("glitch_back_idle", {30'd0, baud_ena, busy}, 32'd0);

    send_frame(8'h3C, 1'b0);
    idle(30);
    send_frame(8'h81, 1'b1);
    idle(5);

    set_ready(1'b0);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(20);
    check("overrun_data_kept", {24'd0, rx_data}, 32'h3C);
    check("overrun_valid_held", {31'd0, rx_valid}, 32'd1);
    set_ready(1'b1);
    step();
    check("valid_clears_after_accept", {31'd0, rx_valid}, 32'd0);
    idle(5);

    // Reset pulse in the middle of data bit 4 of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (8) step();
    rstn = 1'b0;
    step();
    check_reset("midframe_reset");
    rstn = 1'b1;
    idle(40);
    check("post_reset_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1);
    idle(5);

    // 0x11 left pending, then accepted in the very cycle 0x77 completes.
    set_ready(1'b0);
    send_frame(8'h11, 1'b1);
    idle(5);
    b77 = 8'h77;
    push(EV_DATA, b77);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b77[i]);
    rx = 1'b1;
    raised = 1'b0;
    repeat (16) begin
      step();
      if (baud_tick && !raised) begin
        rx_ready = 1'b1;
        raised = 1'b1;
      end
    end
    pending = 1'b0;
    check("stop_tick_seen", {31'd0, raised}, 32'd1);
    check("same_cycle_data", {24'd0, rx_data}, 32'h77);
    idle(5);

    for (int n = 0; n < 14; n++) begin
      b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      set_ready(1'($urandom_range(0, 1)));
      send_frame(b, ok);
      idle(ok ? int'($urandom_range(0, 8)) : 30);
    end

    set_ready(1'b1);
    idle(20);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive framer. It sits directly downstream of the receive baud-tick generator and drives that generator's clock-enable input.
- Synchronises the serial rx line, detects the start bit and enables the tick generator. Samples each bit on the mid-bit tick, assembles an LSB-first byte and presents it on a valid/ready interface to the packet/command layer.
- Flags framing errors and overruns.

Parameters:
DATA_BITS, 8, number of data bits per frame (1 start, DATA_BITS data, 1 stop; no parity)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
rx  in  1  asynchronous serial input, idle high
baud_tick  in  1  one-cycle mid-bit pulse from the baud tick generator
baud_ena  out  1  clock enable to the baud tick generator; high while a frame is in progress
rx_data  out  DATA_BITS  received byte, LSB = first data bit on the line
rx_valid  out  1  rx_data holds an unconsumed byte
rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: frame completed while the previous byte was still unconsumed
busy  out  1  state != IDLE

Behaviour:
- Single clock domain. Reset is synchronous and active-low (rstn sampled on posedge clk) and applies everywhere, including mid-frame.
- Reset values:
  - rx synchroniser flops = 1
  - state = IDLE, bit_cnt = 0, shift register = 0
  - baud_ena = 0, rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
- baud_tick contract: after baud_ena rises, the generator restarts from 0. The first tick arrives about half a bit period later (middle of the start bit), then one tick per bit period. baud_ena must stay continuously high for the whole frame.
- baud_ena is a registered output: high in START/DATA/STOP, low in IDLE.
- FSM transitions (evaluated only when baud_tick = 1, except IDLE):
  - IDLE: if rx_s == 0 -> START (baud_ena goes 1 next cycle).
  - START, tick: rx_s == 0 -> DATA, bit_cnt = 0. rx_s == 1 -> IDLE (false start/glitch: no output, no flag).
  - DATA, tick: shreg <= {rx_s, shreg[DATA_BITS-1:1]}, bit_cnt++. On the tick with bit_cnt == DATA_BITS-1 -> STOP.
  - STOP, tick: -> IDLE always.
    - rx_s == 1: deliver the byte (see output rules).
    - rx_s == 0: frame_err = 1 for exactly the next cycle; byte discarded; rx_valid/rx_data unchanged.
- IDLE holds baud_ena low for at least one cycle between frames, so the generator re-phases on every start edge.
- Ticks arriving in IDLE are ignored.
- Output rules:
  - Delivery latency: rx_data/rx_valid update on the cycle after the stop-bit tick.
  - rx_valid stays high and rx_data stays stable until a cycle with rx_valid && rx_ready. rx_valid clears the following cycle unless a new byte is delivered in that same cycle.
  - Delivery while rx_valid == 0, or while rx_valid && rx_ready in the same cycle: load rx_data, rx_valid = 1.
  - Delivery while rx_valid && !rx_ready: new byte dropped, old rx_data kept, overrun = 1 for one cycle.
  - frame_err and overrun are never both set by the same frame.
- Mid-frame reset: the next cycle is the full reset state. The next falling edge starts a fresh frame.
- bit_cnt width: $clog2(DATA_BITS)+1; never wraps within a frame.

Test Plan:
- Bench setup: pair with the baud tick generator at divisor 16 (mid tick at count 8), rx_ready held 1. Frame 0xA5 (line order 0,1,0,1,0,0,1,0,1,1) -> rx_data = 0xA5, rx_valid one cycle, frame_err = 0, overrun = 0, baud_ena back to 0 after the stop tick.
- rx low for 3 cycles then high, no frame -> FSM returns IDLE at the first tick; rx_valid and frame_err stay 0; baud_ena drops.
- Frame 0x3C with stop bit driven 0 -> frame_err pulses exactly 1 cycle; rx_valid stays 0; next frame 0x81 received correctly.
- rx_ready = 0; frames 0x3C then 0xC3 back-to-back -> rx_valid held with 0x3C; overrun pulses once at 0xC3 completion. Raise rx_ready -> 0x3C consumed, rx_valid clears next cycle.
- rstn low for 1 cycle during data bit 4 of 0xFF -> next cycle all outputs at reset values. Following frame 0x5A -> rx_data = 0x5A.
- rx_valid && rx_ready in the same cycle as completion of 0x77 (previous 0x11 pending) -> 0x11 accepted, rx_data = 0x77, rx_valid stays 1, no overrun.
